// File: rtl/puf_crp_sequencer.sv
// Challenge/response sequencer for an arbiter PUF. An LFSR supplies the challenges, one response
// bit is sampled per challenge, and RESP_BITS bits are packed into a word handed off over valid/ready.
module puf_crp_sequencer #(
  parameter int CH_W      = 64,
  parameter int RESP_BITS = 32,
  parameter int SETTLE    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_load,
  input  logic [CH_W-1:0]      seed,
  input  logic                 start,
  output logic [CH_W-1:0]      challenge,
  input  logic                 response,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] resp_data,
  input  logic                 resp_ready,
  output logic [15:0]          word_count
);

  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

  logic [1:0]           state_reg;
  logic [CH_W-1:0]      lfsr_reg;
  logic [CH_W-1:0]      challenge_reg;
  logic [RESP_BITS-1:0] resp_data_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic [CNT_W-1:0]     settle_cnt_reg;
  logic [15:0]          word_count_reg;
  logic                 busy_reg;
  logic                 resp_valid_reg;

  logic [CH_W-1:0]      lfsr_next;
  logic [CH_W-1:0]      seed_eff;
  logic [RESP_BITS-1:0] capture_en;
  logic [RESP_BITS-1:0] resp_data_next;

  // x^64 + x^63 + x^61 + x^60 + 1, shifting towards the MSB
  assign lfsr_next = {lfsr_reg[CH_W-2:0],
                      lfsr_reg[CH_W-1] ^ lfsr_reg[CH_W-2] ^ lfsr_reg[CH_W-4] ^ lfsr_reg[CH_W-5]};

  // An all-zero LFSR would lock up, so a zero seed maps to 1
  assign seed_eff = (seed == '0) ? CH_W'(1) : seed;

  genvar gi;
  generate
    for (gi = 0; gi < RESP_BITS; gi++) begin : g_capture
      assign capture_en[gi] = (bit_idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign resp_data_next = (resp_data_reg & ~capture_en) | ({RESP_BITS{response}} & capture_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      lfsr_reg       <= CH_W'(1);
      challenge_reg  <= '0;
      resp_data_reg  <= '0;
      bit_idx_reg    <= '0;
      settle_cnt_reg <= '0;
      word_count_reg <= '0;
      busy_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (seed_load) lfsr_reg <= seed_eff;
          if (start) begin
            challenge_reg  <= seed_load ? seed_eff : lfsr_reg;
            settle_cnt_reg <= '0;
            bit_idx_reg    <= '0;
            state_reg      <= S_SETTLE;
            busy_reg       <= 1'b1;
          end
        end
        S_SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg + CNT_W'(1);
          if (settle_cnt_reg == LAST_CNT) state_reg <= S_SAMPLE;
        end
        S_SAMPLE: begin
          // lfsr advances on every sample so it always names the next unused challenge
          resp_data_reg <= resp_data_next;
          lfsr_reg      <= lfsr_next;
          if (bit_idx_reg == LAST_IDX) begin
            state_reg      <= S_HOLD;
            resp_valid_reg <= 1'b1;
          end else begin
            bit_idx_reg    <= bit_idx_reg + IDX_W'(1);
            challenge_reg  <= lfsr_next;
            settle_cnt_reg <= '0;
            state_reg      <= S_SETTLE;
          end
        end
        S_HOLD: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            word_count_reg <= word_count_reg + 16'd1;
            state_reg      <= S_IDLE;
            busy_reg       <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign challenge  = challenge_reg;
  assign busy       = busy_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Randomized bench for puf_crp_sequencer (RESP_BITS=8, SETTLE=2) against a word-level model
// that tracks the expected challenge sequence, packed word and handoff count.
module tb_puf_crp_sequencer;

  localparam int RB = 8;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_load = 1'b0;
  logic [63:0]   seed = '0;
  logic          start = 1'b0;
  logic [63:0]   challenge;
  logic          response = 1'b0;
  logic          busy;
  logic          resp_valid;
  logic [RB-1:0] resp_data;
  logic          resp_ready = 1'b0;
  logic [15:0]   word_count;

  int checks = 0;
  int errors = 0;

  // Model state: next unused challenge and expected handoff count
  logic [63:0] m_lfsr = 64'd1;
  logic [15:0] m_wc = '0;

  puf_crp_sequencer #(.CH_W(64), .RESP_BITS(RB), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .start(start),
    .challenge(challenge), .response(response), .busy(busy), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_ready(resp_ready), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] lfsr_step(input logic [63:0] x);
    return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
  endfunction

  // Called just after a negedge with the DUT idle. abort_bit >= 0 resets mid-word.
  task automatic run_word(input bit do_seed, input logic [63:0] sd, input logic [RB-1:0] want,
                          input bit noise, input bit poke, input int hold, input int abort_bit);
    logic [63:0] exp_ch;
    logic [63:0] last_ch;
    last_ch = '0;
    start = 1'b1;
    seed_load = do_seed;
    seed = sd;
    if (do_seed) m_lfsr = (sd == 64'd0) ? 64'd1 : sd;
    exp_ch = m_lfsr;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < RB; k++) begin
      for (int c = 0; c <= ST; c++) begin
        if (k == abort_bit && c == 0) begin
          rst = 1'b1; start = 1'b0; seed_load = 1'b0;
          @(posedge clk); @(negedge clk);
          rst = 1'b0;
          check("rst_busy", busy, 0);
          check("rst_valid", resp_valid, 0);
          check("rst_data", resp_data, 0);
          check("rst_chal", challenge, 0);
          check("rst_wc", word_count, 0);
          m_lfsr = 64'd1;
          m_wc = '0;
          $display("word aborted by reset at bit %0d", k);
          return;
        end
        check("chal", challenge, exp_ch);
        check("busy_run", busy, 1);
        check("valid_run", resp_valid, 0);
        response = (c == ST || !noise) ? want[k] : 1'($urandom);
        if (poke && k == 2 && c == 1) begin
          start = 1'b1; seed_load = 1'b1; seed = {$urandom, $urandom};
        end else begin
          start = 1'b0; seed_load = 1'b0;
        end
        @(posedge clk); @(negedge clk);
      end
      last_ch = exp_ch;
      exp_ch = lfsr_step(exp_ch);
    end
    m_lfsr = exp_ch;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, want);
      check("hold_chal", challenge, last_ch);
      response = 1'($urandom);
      @(posedge clk); @(negedge clk);
    end
    check("valid_up", resp_valid, 1);
    check("word", resp_data, want);
    check("busy_hold", busy, 1);
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    m_wc = m_wc + 16'd1;
    check("valid_drop", resp_valid, 0);
    check("busy_idle", busy, 0);
    check("word_count", word_count, m_wc);
    check("idle_chal", challenge, last_ch);
    $display("word data=%h first_seed=%0d wc=%h", resp_data, do_seed, word_count);
  endtask

  initial begin
    logic [RB-1:0] w;
    logic [63:0]   s;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", resp_valid, 0);
    check("idle_chal", challenge, 0);
    check("idle_wc", word_count, 0);
    check("idle_data", resp_data, 0);

    run_word(1'b1, 64'd1, 8'hFF, 1'b0, 1'b0, 0, -1);
    run_word(1'b0, 64'd0, 8'hAA, 1'b1, 1'b0, 10, -1);
    run_word(1'b1, 64'd0, 8'($urandom), 1'b1, 1'b1, 2, -1);

    for (int n = 0; n < 6; n++) begin
      s = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      w = 8'($urandom);
      run_word(1'($urandom), s, w, 1'b1, 1'($urandom), int'($urandom_range(0, 5)), -1);
    end

    force dut.word_count_reg = 16'hFFFF;
    #1;
    release dut.word_count_reg;
    m_wc = 16'hFFFF;
    @(negedge clk);
    check("wc_preset", word_count, m_wc);
    run_word(1'b0, 64'd0, 8'($urandom), 1'b1, 1'b0, 1, -1);

    run_word(1'b1, {$urandom, $urandom}, 8'($urandom), 1'b1, 1'b0, 0, 3);
    run_word(1'b0, 64'd0, 8'($urandom), 1'b1, 1'b0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_crp_sequencer.md
Name: puf_crp_sequencer

Overview:
- Upstream/downstream companion of the arbiter PUF top: generates a pseudo-random 64-bit challenge stream from an LFSR, drives it into the PUF, and waits a programmable settle time.
- Samples the PUF's 1-bit response after each settle period and packs RESP_BITS responses into one word.
- Hands the word to the consumer (e.g. a key extractor or host FIFO) over a valid/ready handshake.

Parameters:
- CH_W, 64, challenge width; fixed LFSR polynomial assumes 64.
- RESP_BITS, 32, responses packed per output word; 1..64.
- SETTLE, 4, cycles a challenge is held before its response is sampled; must be at least 1, because the PUF arbiter registers its response on clk.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- seed_load  input  1  load seed into LFSR (honoured in IDLE only)
- seed  input  CH_W  LFSR seed value
- start  input  1  begin collecting one word (honoured in IDLE only)
- challenge  output  CH_W  registered challenge to PUF
- response  input  1  PUF response bit
- busy  output  1  high in any state except IDLE
- resp_valid  output  1  packed word available
- resp_data  output  RESP_BITS  packed responses; bit k holds the response to the k-th challenge of the word
- resp_ready  input  1  consumer accepts the word
- word_count  output  16  words handed off since reset

Behaviour:
- Reset (clk edge with rst=1) sets state IDLE and lfsr=64'h1, and clears challenge, resp_data, bit index, settle counter, word_count, busy and resp_valid. Reset takes priority in every state, so a collection in progress is abandoned and no partial word is presented.
- LFSR update: lfsr_next = {lfsr[62:0], fb}, where fb = lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59] (x^64+x^63+x^61+x^60+1). A seed of all zeros loads 64'h1 instead.
- FSM states: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - seed_load=1: lfsr<=seed.
  - start=1: challenge<=lfsr, or seed if seed_load is also 1 in the same cycle, so the new seed is used immediately. Then settle counter=0, bit index=0, state→SETTLE.
- SETTLE: challenge held stable; settle counter increments each cycle. On the edge where the counter equals SETTLE-1, state→SAMPLE.
- SAMPLE, one cycle; at its closing edge:
  - resp_data[bit index]<=response.
  - lfsr advances; lfsr always holds the next unused challenge.
  - If bit index = RESP_BITS-1: state→HOLD, resp_valid<=1.
  - Otherwise: bit index++, challenge<=advanced lfsr value, settle counter=0, state→SETTLE.
- Timing: each challenge lasts exactly SETTLE+1 cycles. With start sampled at edge 0, bit k is captured at edge (k+1)(SETTLE+1), and resp_valid rises after edge RESP_BITS*(SETTLE+1).
- HOLD:
  - resp_valid=1; resp_data and challenge are stable.
  - On an edge with resp_ready=1: resp_valid<=0, word_count++ (wraps FFFF→0000), state→IDLE.
  - resp_ready=0 holds indefinitely.
- start and seed_load are ignored outside IDLE. resp_ready is ignored outside HOLD.
- In IDLE, challenge keeps the last applied value.
- The next start continues the LFSR sequence where the last word ended; no reseed is needed.
- busy = (state != IDLE); it is registered with the state.

Test Plan:
- Reset and idle: assert rst 2 cycles, then idle 5 cycles → busy=0, resp_valid=0, challenge=0, word_count=0.
- Sequence check (RESP_BITS=8, SETTLE=2): seed_load seed=64'h1, then start. Expected results:
  - challenge = 1, 2, 4, 8, 16, 32, 64, 128, each held 3 cycles.
  - response tied 1 → resp_valid rises after edge 24 with resp_data=8'hFF.
- Bit ordering: drive response = low bit of the challenge's index (0,1,0,1,…) → resp_data=8'hAA. With resp_ready low 10 cycles, the word and valid hold steady. Pulse resp_ready → valid drops next edge, word_count=1, busy=0.
- Zero seed and start/seed collision: seed_load and start in the same cycle with seed=0 → first challenge=64'h1. A second start and seed_load issued mid-run are ignored (busy stays high, sequence unchanged).
- Continuation and wrap: with a second start after handoff, the first challenge equals the LFSR successor of the previous word's last challenge (256 for the test above). Force word_count to 16'hFFFF via back-to-back words (or a bench-shortened run) → the next handoff wraps it to 0.
- Reset mid-operation: assert rst during SETTLE of bit 3 → next cycle busy=0, resp_valid=0, resp_data=0, lfsr=1. A new start then yields challenge=1 first.
